uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART. It consumes the one-cycle baud tick from the baud-rate generator and accepts one character per valid/ready handshake. It serialises the character as start, data (LSB first), optional parity and 1 or 2 stop bits onto the TX line. Frame format is latched per character, so configuration writes never corrupt a frame in flight.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
baud_tick_i  input  1  one-cycle pulse, one per bit period, from the baud generator
tx_data_i  input  DATA_W  character to send
tx_valid_i  input  1  character available
tx_ready_o  output  1  controller can accept a character
par_en_i  input  1  parity bit enabled
par_odd_i  input  1  1 = odd parity, 0 = even parity
stop2_i  input  1  1 = two stop bits, 0 = one stop bit
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress (any state except IDLE)
done_o  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (rst_i high at a clock edge), effective next cycle:
  - tx_o=1, tx_ready_o=1, busy_o=0, done_o=0
  - state=IDLE; bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; no stop bit is emitted.
- Handshake:
  - Accept occurs when tx_valid_i && tx_ready_o at a clock edge.
  - tx_ready_o = (state==IDLE), registered.
  - On accept: latch tx_data_i, par_en_i, par_odd_i and stop2_i; compute parity from the latched data (XOR of bits, inverted when odd).
  - Config inputs are ignored outside the accept cycle.
- FSM states: IDLE, SYNC, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on accept -> SYNC. baud_tick_i is ignored.
  - SYNC: tx_o held 1. On baud_tick_i -> START. This aligns the start bit to a tick, so every bit lasts exactly one full tick interval.
  - START: tx_o=0. On tick -> DATA with bit index 0.
  - DATA: tx_o = data[index]. On tick: index==DATA_W-1 -> PARITY if par_en, else STOP1; otherwise index+1.
  - PARITY: tx_o = parity bit. On tick -> STOP1.
  - STOP1: tx_o=1. On tick -> STOP2 if stop2, else IDLE with done pulse.
  - STOP2: tx_o=1. On tick -> IDLE with done pulse.
- Timing:
  - All state transitions happen only at edges where baud_tick_i=1 (except IDLE->SYNC).
  - tx_o is registered and reflects the new state the cycle after the transition edge.
  - done_o is high for exactly the one cycle after the final-stop tick edge; tx_ready_o rises in the same cycle.
  - The earliest next accept is that same cycle, giving back-to-back frames separated only by SYNC wait (<= 1 tick period).
- Outputs and edge cases:
  - busy_o = (state != IDLE), registered.
  - tx_valid_i dropping after accept has no effect.
  - baud_tick_i held high continuously advances one bit per clock; this is legal and used in test.
  - The bit index counter is ceil(log2(DATA_W)) bits wide, with no wrap beyond DATA_W-1.

Test Plan:
- Reset/idle: assert rst_i 2 cycles, tick every 4 cycles, no valid -> tx_o=1, tx_ready_o=1, busy_o=0, done_o never pulses.
- Basic frame: 0xA5, par_en=0, stop2=0, tick every 4 cycles -> tx_o per bit period: 0,1,0,1,0,0,1,0,1,1 (10 bit periods). Each bit lasts exactly 4 cycles. Exactly one done_o pulse; tx_ready_o low from the cycle after accept until done.
- Parity/stop: 0xA5 even parity -> parity bit 0; odd parity -> 1. With stop2=1 the line stays high for 2 bit periods before done_o. Change par_odd_i mid-frame -> no effect on the frame.
- Back-to-back: hold tx_valid_i with 0x00 then 0xFF -> second accept in the done_o cycle. Second start bit begins at the first tick after accept; no glitch on tx_o.
- Reset mid-frame: rst_i during DATA bit 3 -> next cycle tx_o=1, state IDLE, tx_ready_o=1, no done_o. A following frame is sent correctly.
- Corners: DATA_W=5 with 0x15, and DATA_W=9 with 0x1AB and parity -> correct bit counts. baud_tick_i tied high -> frame completes in 1+1+DATA_W+par+stop cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, LSB-first data, optional parity, 1/2 stops.
// Frame format is captured at accept so config writes never touch a live frame.
module uart_tx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baud_tick_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic              par_en_i,
  input  logic              par_odd_i,
  input  logic              stop2_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              tx_d, done_d;
  logic              accept;

  assign accept = tx_valid_i && tx_ready_o;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SYNC;
          sh_d     = tx_data_i;
          idx_d    = '0;
          par_en_d = par_en_i;
          par_d    = (^tx_data_i) ^ par_odd_i;
          stop2_d  = stop2_i;
        end
      end
      SYNC: begin
        if (baud_tick_i) state_d = START;
      end
      START: begin
        if (baud_tick_i) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (baud_tick_i) begin
          if (idx_q == LAST) begin
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_tick_i) state_d = STOP1;
      end
      STOP1: begin
        if (baud_tick_i) begin
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (baud_tick_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx_o can be a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      tx_o       <= 1'b1;
      tx_ready_o <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      tx_o       <= tx_d;
      tx_ready_o <= (state_d == IDLE);
      busy_o     <= (state_d != IDLE);
      done_o     <= done_d;
    end
  end

endmodule
